// File: rtl/io_bus_pkg.sv
// Shared definitions for the memory-mapped I/O bus: FSM states, region decode
// constants and the addresses of the devices hanging off the bus.
package io_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } bus_state_e;

  localparam logic [31:0] IO_BASE   = 32'hF000_0000;
  localparam logic [31:0] IO_MASK   = 32'hF000_0000;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_0000;

  localparam logic [31:0] TCNT = 32'hF000_0020;
  localparam logic [31:0] TLIM = 32'hF000_0024;
  localparam logic [31:0] TCTL = 32'hF000_0120;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the registered device IRQ lines.
module irq_prio_enc #(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               intr_req_o,
  output logic [IDW-1:0]     intr_id_o
);

  // Scanning from the top down lets the lowest set index be the last writer.
  always_comb begin
    intr_req_o = |irq_i;
    intr_id_o  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_i[i]) begin
        intr_id_o = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/io_bus_master.sv
// CPU-side initiator for the shared aBus/dBus/wrtEn I/O bus: one bus cycle per
// accepted request, a one-cycle response, and a registered IRQ priority encoder.
module io_bus_master #(
  parameter int unsigned                ABUS_WIDTH = 32,
  parameter int unsigned                DBUS_WIDTH = 32,
  parameter logic [ABUS_WIDTH-1:0]      IO_BASE    = ABUS_WIDTH'(io_bus_pkg::IO_BASE),
  parameter logic [ABUS_WIDTH-1:0]      IO_MASK    = ABUS_WIDTH'(io_bus_pkg::IO_MASK),
  parameter logic [ABUS_WIDTH-1:0]      IDLE_ADDR  = ABUS_WIDTH'(io_bus_pkg::IDLE_ADDR),
  parameter int unsigned                NUM_IRQ    = 4,
  localparam int unsigned               IRQ_IDW    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ABUS_WIDTH-1:0] req_addr,
  input  logic [DBUS_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DBUS_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ABUS_WIDTH-1:0] aBus,
  inout  tri   [DBUS_WIDTH-1:0] dBus,
  output logic                  wrtEn,
  input  logic [NUM_IRQ-1:0]    irq_in,
  output logic                  intr_req,
  output logic [IRQ_IDW-1:0]    intr_id
);

  import io_bus_pkg::*;

  bus_state_e            state_q, state_d;
  logic                  wr_q;
  logic                  hit_q;
  logic [ABUS_WIDTH-1:0] addr_q;
  logic [DBUS_WIDTH-1:0] wdata_q;
  logic [DBUS_WIDTH-1:0] rdata_q;
  logic [NUM_IRQ-1:0]    irq_q;
  logic                  accept;
  logic                  busCycle;

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      hit_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= req_wr;
      hit_q   <= ((req_addr & IO_MASK) == IO_BASE);
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Read data is captured at the edge closing DRIVE; anything else answers 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (state_q == ST_DRIVE) begin
      rdata_q <= (hit_q && !wr_q) ? dBus : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_in;
    end
  end

  // Bus outputs decode only registered state, so reset releases them at once.
  assign busCycle   = (state_q == ST_DRIVE) && hit_q;
  assign aBus       = busCycle ? addr_q : IDLE_ADDR;
  assign wrtEn      = busCycle && wr_q;
  assign dBus       = wrtEn ? wdata_q : 'z;

  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid && !hit_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDW     (IRQ_IDW)
  ) u_irq_prio_enc (
    .irq_i      (irq_q),
    .intr_req_o (intr_req),
    .intr_id_o  (intr_id)
  );

endmodule

// File: tb/tb_io_bus_master.sv
// Self-checking bench for io_bus_master: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
module tb_io_bus_master;
  import io_bus_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] aBus;
  tri   [31:0] dBus;
  logic        wrtEn;
  logic [3:0]  irq_in;
  logic        intr_req;
  logic [1:0]  intr_id;

  logic [31:0] devValue;
  logic        devEn;
  logic        modelOn;
  logic        irqRandom;

  int checks = 0;
  int errors = 0;

  // A bench device answers reads anywhere in the I/O region.
  assign devEn = !wrtEn && (aBus[31:28] == 4'hF);
  assign dBus  = devEn ? devValue : 'z;

  io_bus_master dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .aBus       (aBus),
    .dBus       (dBus),
    .wrtEn      (wrtEn),
    .irq_in     (irq_in),
    .intr_req   (intr_req),
    .intr_id    (intr_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowestSet(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Model: cycles since acceptance (0 = idle, 1 = bus cycle, 2 = response).
  int          phase = 0;
  logic        mWr, mHit;
  logic [31:0] mAddr, mWdata, mRdata;
  logic [3:0]  irqPrev = 4'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase   = 0;
      irqPrev = 4'b0;
    end else begin
      irqPrev = irq_in;
      if (phase == 0) begin
        if (req_valid) begin
          mWr    = req_wr;
          mAddr  = req_addr;
          mWdata = req_wdata;
          mHit   = (req_addr[31:28] == 4'hF);
          mRdata = (mHit && !req_wr) ? devValue : 32'h0;
          phase  = 1;
        end
      end else if (phase == 1) begin
        phase = 2;
      end else begin
        phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("m_ready", {31'b0, req_ready}, {31'b0, phase == 0});
      checkOutput("m_aBus", aBus, (phase == 1 && mHit) ? mAddr : 32'h0);
      checkOutput("m_wrtEn", {31'b0, wrtEn}, {31'b0, phase == 1 && mHit && mWr});
      if (phase == 1 && mHit && mWr) checkOutput("m_dBus", dBus, mWdata);
      checkOutput("m_resp_valid", {31'b0, resp_valid}, {31'b0, phase == 2});
      checkOutput("m_resp_err", {31'b0, resp_err}, {31'b0, phase == 2 && !mHit});
      checkOutput("m_resp_rdata", resp_rdata, (phase == 2) ? mRdata : 32'h0);
      checkOutput("m_intr_req", {31'b0, intr_req}, {31'b0, |irqPrev});
      checkOutput("m_intr_id", {30'b0, intr_id}, 32'(lowestSet(irqPrev)));
    end
  end

  always @(posedge clk) begin
    if (irqRandom) begin
      #1 irq_in = 4'($urandom);
    end
  end

  // Presents a request, waits for ready, returns 1 time unit after acceptance.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] dev);
    int n = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 20) begin
        errors++;
        $display("[TB] FAIL accept_timeout: req_ready stayed %b, expected 1", req_ready);
        break;
      end
    end
    devValue = dev;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  logic rdy [4];

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    irq_in = 4'b0; devValue = '0; modelOn = 1'b1; irqRandom = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_aBus", aBus, 32'h0);
    checkOutput("rst_wrtEn", {31'b0, wrtEn}, 32'd0);
    checkOutput("rst_intr", {29'b0, intr_req, intr_id}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    applyStimulus(1'b1, TLIM, 32'd5, 32'h0);
    @(negedge clk);
    checkOutput("wr_aBus", aBus, 32'hF000_0024);
    checkOutput("wr_dBus", dBus, 32'd5);
    checkOutput("wr_wrtEn", {31'b0, wrtEn}, 32'd1);
    @(negedge clk);
    checkOutput("wr_wrtEn_off", {31'b0, wrtEn}, 32'd0);
    checkOutput("wr_resp", {resp_valid, resp_err, 30'b0}, 32'h8000_0000);
    checkOutput("wr_rdata", resp_rdata, 32'h0);

    applyStimulus(1'b0, TCNT, 32'h0, 32'h1234);
    @(negedge clk);
    checkOutput("rd_wrtEn", {31'b0, wrtEn}, 32'd0);
    checkOutput("rd_aBus", aBus, 32'hF000_0020);
    @(negedge clk);
    checkOutput("rd_rdata", resp_rdata, 32'h1234);
    checkOutput("rd_resp", {resp_valid, resp_err, 30'b0}, 32'h8000_0000);

    applyStimulus(1'b0, 32'h0000_1000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("err_aBus", aBus, 32'h0);
    checkOutput("err_wrtEn", {31'b0, wrtEn}, 32'd0);
    @(negedge clk);
    checkOutput("err_resp", {resp_valid, resp_err, 30'b0}, 32'hC000_0000);
    checkOutput("err_rdata", resp_rdata, 32'h0);

    // Held request: write then read to TCTL with req_valid never dropping.
    req_valid = 1'b1; req_wr = 1'b1; req_addr = TCTL; req_wdata = 32'd77;
    devValue = 32'hCAFE_0001;
    @(negedge clk);
    rdy[0] = req_ready;
    @(posedge clk); #1 req_wr = 1'b0;
    @(negedge clk);
    rdy[1] = req_ready;
    checkOutput("b2b_first_wrtEn", {31'b0, wrtEn}, 32'd1);
    @(negedge clk);
    rdy[2] = req_ready;
    checkOutput("b2b_idle_bus", aBus, 32'h0);
    @(negedge clk);
    rdy[3] = req_ready;
    @(posedge clk); #1 req_valid = 1'b0;
    checkOutput("b2b_ready_pattern", {28'b0, rdy[0], rdy[1], rdy[2], rdy[3]}, 32'b1001);
    @(negedge clk);
    checkOutput("b2b_second_aBus", aBus, 32'hF000_0120);
    checkOutput("b2b_second_wrtEn", {31'b0, wrtEn}, 32'd0);
    @(negedge clk);
    checkOutput("b2b_rdata", resp_rdata, 32'hCAFE_0001);

    applyStimulus(1'b1, TLIM, 32'hDEAD_BEEF, 32'h0);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_wrtEn", {31'b0, wrtEn}, 32'd0);
    checkOutput("arst_dBus_released", {31'b0, dBus !== 32'hDEAD_BEEF}, 32'd1);
    checkOutput("arst_aBus", aBus, 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("arst_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("arst_no_resp", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    checkOutput("arst_no_resp2", {31'b0, resp_valid}, 32'd0);

    @(posedge clk); #1 irq_in = 4'b1010;
    @(negedge clk);
    checkOutput("irq_not_yet", {31'b0, intr_req}, 32'd0);
    @(negedge clk);
    checkOutput("irq_req", {31'b0, intr_req}, 32'd1);
    checkOutput("irq_id", {30'b0, intr_id}, 32'd1);
    @(posedge clk); #1 irq_in = 4'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("irq_clear", {29'b0, intr_req, intr_id}, 32'd0);

    irqRandom = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      int gap;
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[31:28] = 4'($urandom_range(0, 14));
      else                           a[31:28] = 4'hF;
      applyStimulus(1'($urandom), a, $urandom, $urandom);
    end
    repeat (4) @(posedge clk);
    irqRandom = 1'b0;
    repeat (3) @(negedge clk);
    modelOn = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
